pipe_ctrl: RTL and testbench



---
 rtl/pipe_ctrl_pkg.sv | 32 +++
 rtl/pipe_ctrl.sv | 140 ++++++++++++++
 tb/tb_pipe_ctrl.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and encodings for the pipeline sequencing controller.
// Hold levels, FSM states and the hold-level arbitration helper.
package pipe_ctrl_pkg;

    localparam logic [2:0] HOLD_NONE = 3'd0;
    localparam logic [2:0] HOLD_PC   = 3'd1;
    localparam logic [2:0] HOLD_IF   = 3'd2;
    localparam logic [2:0] HOLD_ID   = 3'd3;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // ex and interrupt stalls freeze the whole front end; bus only the pc
    function automatic logic [2:0] hold_level(
        input logic ex,
        input logic bus,
        input logic intr
    );
        logic [2:0] lv;
        lv = HOLD_NONE;
        if (ex || intr) begin
            lv = HOLD_ID;
        end else if (bus) begin
            lv = HOLD_PC;
        end
        return lv;
    endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Front-end pipeline controller: hold arbitration, redirect and flush timing.
// Optional PIPE_CTRL_STAT_EN adds saturating stall/flush cycle counters.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int FLUSH_CYCLES = 1,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              hold_ex_i,
    input  logic              hold_bus_i,
    input  logic              hold_int_i,
    output logic [2:0]        hold_flag_o,
    output logic              jump_flag_o,
    output logic [ADDR_W-1:0] jump_addr_o,
    output logic              rst_if_id_o,
    output logic              rst_id_ex_o,
`ifdef PIPE_CTRL_STAT_EN
    output logic [31:0]       stall_cnt_o,
    output logic [31:0]       flush_cnt_o,
`endif
    output logic              busy_o
);

    localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);
    localparam bit         MULTI    = (FLUSH_CYCLES > 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;

    logic [2:0]        level;
    logic              issue;
    logic [ADDR_W-1:0] issue_addr;
    logic              flush;

    // next-state, deferred-jump capture and redirect/flush decode
    always_comb begin
        level       = hold_level(hold_ex_i, hold_bus_i, hold_int_i);
        state_d     = state_q;
        cnt_d       = cnt_q;
        pend_d      = pend_q;
        pend_addr_d = pend_addr_q;
        issue       = 1'b0;
        issue_addr  = '0;
        flush       = 1'b0;
        unique case (state_q)
            RUN: begin
                if (level != HOLD_NONE) begin
                    state_d = HOLD;
                    if (jump_flag_i) begin
                        pend_d      = 1'b1;
                        pend_addr_d = jump_addr_i;
                    end
                end else if (jump_flag_i) begin
                    issue      = 1'b1;
                    issue_addr = jump_addr_i;
                end
            end
            FLUSH: begin
                flush = 1'b1;
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = (level != HOLD_NONE) ? HOLD : RUN;
                end
            end
            HOLD: begin
                flush = pend_q;
                if (level != HOLD_NONE) begin
                    if (jump_flag_i && !pend_q) begin
                        pend_d      = 1'b1;
                        pend_addr_d = jump_addr_i;
                    end
                end else if (pend_q) begin
                    issue      = 1'b1;
                    issue_addr = pend_addr_q;
                    pend_d     = 1'b0;
                end else if (jump_flag_i) begin
                    issue      = 1'b1;
                    issue_addr = jump_addr_i;
                end else begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
        if (issue) begin
            flush   = 1'b1;
            state_d = MULTI ? FLUSH : RUN;
            cnt_d   = CNT_INIT;
        end
    end

    // state, flush counter and pending jump registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= RUN;
            cnt_q       <= 4'd0;
            pend_q      <= 1'b0;
            pend_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end

    assign hold_flag_o = level;
    assign jump_flag_o = issue;
    assign jump_addr_o = issue_addr;
    assign rst_if_id_o = flush;
    assign rst_id_ex_o = flush;
    assign busy_o      = (state_q != RUN) || pend_q;

`ifdef PIPE_CTRL_STAT_EN
    // saturating counts of stalled and flushed cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= 32'd0;
            flush_cnt_o <= 32'd0;
        end else begin
            if (level != HOLD_NONE && stall_cnt_o != 32'hFFFF_FFFF) begin
                stall_cnt_o <= stall_cnt_o + 32'd1;
            end
            if (flush && flush_cnt_o != 32'hFFFF_FFFF) begin
                flush_cnt_o <= flush_cnt_o + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: expected per-cycle outputs are queued
// as stimulus is driven and compared when the cycle's outputs settle.
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        jump_flag_i = 1'b0;
    logic [31:0] jump_addr_i = '0;
    logic        hold_ex_i = 1'b0;
    logic        hold_bus_i = 1'b0;
    logic        hold_int_i = 1'b0;

    logic [2:0]  hold1, hold3;
    logic        jf1, jf3, rif1, rif3, rie1, rie3, busy1, busy3;
    logic [31:0] addr1, addr3;
`ifdef PIPE_CTRL_STAT_EN
    logic [31:0] stall1, flushc1, stall3, flushc3;
`endif

    int n_vec = 0;
    int n_err = 0;
    bit sel3  = 1'b0;

    logic [63:0] exp_q[$];
    string       tag_q[$];

    always #5 clk = ~clk;

    pipe_ctrl #(.FLUSH_CYCLES(1), .ADDR_W(32)) u_fc1 (
        .clk(clk), .rst(rst),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .hold_ex_i(hold_ex_i), .hold_bus_i(hold_bus_i),
        .hold_int_i(hold_int_i),
        .hold_flag_o(hold1), .jump_flag_o(jf1), .jump_addr_o(addr1),
        .rst_if_id_o(rif1), .rst_id_ex_o(rie1),
`ifdef PIPE_CTRL_STAT_EN
        .stall_cnt_o(stall1), .flush_cnt_o(flushc1),
`endif
        .busy_o(busy1)
    );

    pipe_ctrl #(.FLUSH_CYCLES(3), .ADDR_W(32)) u_fc3 (
        .clk(clk), .rst(rst),
        .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
        .hold_ex_i(hold_ex_i), .hold_bus_i(hold_bus_i),
        .hold_int_i(hold_int_i),
        .hold_flag_o(hold3), .jump_flag_o(jf3), .jump_addr_o(addr3),
        .rst_if_id_o(rif3), .rst_id_ex_o(rie3),
`ifdef PIPE_CTRL_STAT_EN
        .stall_cnt_o(stall3), .flush_cnt_o(flushc3),
`endif
        .busy_o(busy3)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        jump_flag_i = 1'b0;
        jump_addr_i = '0;
        hold_ex_i = 1'b0;
        hold_bus_i = 1'b0;
        hold_int_i = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // one cycle: drive inputs, queue expectation, compare at negedge
    task automatic step(input string tag, input logic j,
                        input logic [31:0] a, input logic hx,
                        input logic hb, input logic hi,
                        input logic [2:0] eh, input logic ejf,
                        input logic [31:0] ea, input logic efl,
                        input logic ebusy);
        logic [63:0] obs;
        jump_flag_i = j;
        jump_addr_i = a;
        hold_ex_i   = hx;
        hold_bus_i  = hb;
        hold_int_i  = hi;
        exp_q.push_back({25'd0, eh, ejf, efl, efl, ebusy, ea});
        tag_q.push_back(tag);
        @(negedge clk);
        if (sel3) obs = {25'd0, hold3, jf3, rif3, rie3, busy3, addr3};
        else      obs = {25'd0, hold1, jf1, rif1, rie1, busy1, addr1};
        check(tag_q.pop_front(), obs, exp_q.pop_front());
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset and idle, FLUSH_CYCLES=1
        sel3 = 1'b0;
        do_reset();
        step("idle0", 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
        step("idle1", 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
        // single-cycle redirect
        step("j1_issue", 1, 32'h100, 0, 0, 0, 3'd0, 1, 32'h100, 1, 0);
        step("j1_after", 0, 32'h100, 0, 0, 0, 3'd0, 0, 0, 0, 0);

        // FLUSH_CYCLES=3 redirect, second jump ignored
        sel3 = 1'b1;
        do_reset();
        step("j3_issue", 1, 32'h180, 0, 0, 0, 3'd0, 1, 32'h180, 1, 0);
        step("j3_ign",   1, 32'h1c0, 0, 0, 0, 3'd0, 0, 0, 1, 1);
        step("j3_fl2",   0, 0, 0, 0, 0, 3'd0, 0, 0, 1, 1);
        step("j3_done",  0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);

        // jumps during bus hold: first captured, second ignored
        do_reset();
        step("h_n0", 0, 0,       0, 1, 0, 3'd1, 0, 0, 0, 0);
        step("h_n1", 1, 32'h200, 0, 1, 0, 3'd1, 0, 0, 0, 1);
        step("h_n2", 1, 32'h300, 0, 1, 0, 3'd1, 0, 0, 1, 1);
        step("h_n3", 0, 0,       0, 1, 0, 3'd1, 0, 0, 1, 1);
        step("h_n4", 0, 0,       0, 1, 0, 3'd1, 0, 0, 1, 1);
        step("h_rel", 0, 0,      0, 0, 0, 3'd0, 1, 32'h200, 1, 1);
        step("h_fl1", 0, 0,      0, 0, 0, 3'd0, 0, 0, 1, 1);
        step("h_fl2", 0, 0,      0, 0, 0, 3'd0, 0, 0, 1, 1);
        step("h_run", 0, 0,      0, 0, 0, 3'd0, 0, 0, 0, 0);

        // hold level arbitration
        do_reset();
        step("lv_ex_bus", 0, 0, 1, 1, 0, 3'd3, 0, 0, 0, 0);
        step("lv_bus",    0, 0, 0, 1, 0, 3'd1, 0, 0, 0, 1);
        step("lv_int",    0, 0, 0, 0, 1, 3'd3, 0, 0, 0, 1);
        step("lv_rel",    0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 1);
        step("lv_run",    0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);

        // hold during flush is not aborted, ends in HOLD
        step("fh_issue", 1, 32'h480, 0, 0, 0, 3'd0, 1, 32'h480, 1, 0);
        step("fh_f1",    0, 0, 0, 1, 0, 3'd1, 0, 0, 1, 1);
        step("fh_f2",    0, 0, 0, 1, 0, 3'd1, 0, 0, 1, 1);
        step("fh_rel",   0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 1);
        step("fh_run",   0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);

        // jump coinciding with hold release, no pending jump
        step("sim_hold", 0, 0,       0, 1, 0, 3'd1, 0, 0, 0, 0);
        step("sim_jump", 1, 32'h500, 0, 0, 0, 3'd0, 1, 32'h500, 1, 1);
        step("sim_f1",   0, 0,       0, 0, 0, 3'd0, 0, 0, 1, 1);
        step("sim_f2",   0, 0,       0, 0, 0, 3'd0, 0, 0, 1, 1);
        step("sim_run",  0, 0,       0, 0, 0, 3'd0, 0, 0, 0, 0);

        // jump arriving with hold in RUN is deferred
        step("rh_cap",  1, 32'h600, 0, 1, 0, 3'd1, 0, 0, 0, 0);
        step("rh_pend", 0, 0,       0, 1, 0, 3'd1, 0, 0, 1, 1);
        step("rh_rel",  0, 0,       0, 0, 0, 3'd0, 1, 32'h600, 1, 1);

        // reset while a jump is pending drops it
        do_reset();
        step("rp_cap",  1, 32'h400, 0, 1, 0, 3'd1, 0, 0, 0, 0);
        step("rp_pend", 0, 0,       0, 1, 0, 3'd1, 0, 0, 1, 1);
        do_reset();
        step("rp_idle0", 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);
        step("rp_idle1", 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0);

`ifdef PIPE_CTRL_STAT_EN
        @(negedge clk);
        check("stall_rst", {32'd0, stall3}, 64'd0);
        check("flush_rst", {32'd0, flushc3}, 64'd0);
        @(posedge clk);
        #1;
        step("st_h1", 0, 0, 0, 1, 0, 3'd1, 0, 0, 0, 0);
        step("st_h2", 0, 0, 0, 1, 0, 3'd1, 0, 0, 0, 1);
        step("st_h3", 0, 0, 1, 0, 0, 3'd3, 0, 0, 0, 1);
        step("st_rel", 0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 1);
        @(negedge clk);
        check("stall_cnt", {32'd0, stall3}, 64'd3);
        check("flush_cnt", {32'd0, flushc3}, 64'd0);
        check("stall_fc1", {32'd0, stall1}, 64'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
